unsi_seq_div_24b12b: RTL and testbench
======================================

Name: unsi_seq_div_24b12b

Overview:
- Sequential restoring unsigned divider. It is the inverse datapath of the team's 12x12 unsigned multipliers.
- Takes a 24-bit dividend (the product width) and a 12-bit divisor. Returns a 12-bit quotient and a 12-bit remainder.
- Main use: the evaluation/recovery path, where approximate products are divided back by an operand to measure error.
- Produces one quotient bit per cycle. Uses a valid/ready handshake on both input and output.

Parameters:
- QW, 12: quotient, divisor and remainder width.
- DW, 24: dividend width; fixed at 2*QW.
- CW, 4: iteration counter width, ceil(log2(QW+1)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DW  unsigned dividend.
- divisor  in  QW  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quot  out  QW  quotient.
- rem  out  QW  remainder; 0 when the macro is absent.
- ovf  out  1  quotient overflow or divide-by-zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset, 1 after release; out_valid=0, quot=0, rem=0, ovf=0; counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: 12 iterations.
  - DONE: out_valid=1.
- Accept: in_valid & in_ready at edge t. Operands are latched and in_ready drops at t.
- Overflow check at accept: dividend[DW-1:QW] >= divisor. This covers divisor==0.
  - If true: go to DONE. Result quot=12'hFFF, rem=0, ovf=1. out_valid is visible from edge t onward (1-cycle latency).
- Otherwise go to CALC:
  - Initialise R=dividend[23:12], Q=dividend[11:0], cnt=0.
  - Each cycle form T={R,Q[11]} (13 bits).
  - If T>=divisor: R=T-divisor (fits 12 bits), qbit=1. Else R=T[11:0], qbit=0.
  - Then Q={Q[10:0],qbit}, cnt++.
  - After the 12th iteration (cnt==11 at edge), load quot=Q, rem=R, ovf=0, and go to DONE.
- Latency: out_valid high 13 cycles after the accept edge.
- DONE: quot/rem/ovf held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On out_valid & out_ready go to IDLE. in_ready=1 on the next cycle; no same-cycle re-accept.
- in_valid while busy is ignored. Operands may change freely after the accept edge.
- out_ready asserted outside DONE has no effect.
- Reset mid-CALC or in DONE: the pending result is discarded and all outputs return to reset values.
- Result identity when ovf=0: dividend == quot*divisor + rem, with rem < divisor.

Optional Feature:
- Macro: UNSI_DIV_REM_OUT_EN.
- Defined: rem carries the final partial remainder, registered in DONE.
- Undefined: rem is tied to 0 and no remainder output register exists. The internal R still exists for the iteration.
- Port list is identical in both builds.

Decomposition:
- Package unsi_div_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - localparams QW/DW/CW;
  - QUOT_SAT = 12'hFFF.
- One combinational sub-module, div_step: inputs R[QW-1:0], next dividend bit, divisor; outputs R_next and qbit. The top instantiates it once and iterates it over time.

Test Plan:
- Basic case: dividend=24'd1000, divisor=12'd7, out_ready=1 -> quot=142, rem=6, ovf=0; out_valid exactly 13 cycles after accept.
- Max case: dividend=24'hFFEFFF, divisor=12'hFFF -> quot=12'hFFF, rem=12'hFFE, ovf=0.
- Overflow and divide-by-zero:
  - dividend=24'h00A000, divisor=12'd10 -> ovf=1, quot=12'hFFF, rem=0, out_valid 1 cycle after accept.
  - divisor=0 with any dividend -> same result.
- Backpressure and busy inputs: hold out_ready=0 for 20 cycles with 1000/7 -> outputs stable throughout. in_valid pulses while busy are ignored. Release -> one handshake, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 at iteration 5 of 1000/7 -> out_valid=0 immediately (async). After release, 200/9 -> quot=22, rem=2.
- Macro undefined (rerun the basic case) -> rem=0, quot=142.

Source files
------------

// File: rtl/unsi_seq_div_24b12b_pkg.sv
// Shared types and widths for the sequential 24/12 unsigned divider.
// Used by unsi_seq_div_24b12b and div_step (optional remainder: UNSI_DIV_REM_OUT_EN).
package unsi_div_pkg;

   localparam int QW = 12;
   localparam int DW = 2 * QW;
   localparam int CW = 4;

   localparam logic [QW-1:0] QUOT_SAT = 12'hFFF;
   localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/unsi_seq_div_24b12b_div_step.sv
// One restoring-division step: shift in the next dividend bit, conditionally subtract.
// Purely combinational; the top iterates it once per cycle.
module div_step
   import unsi_div_pkg::*;
(
   input  logic [QW-1:0] r_i,
   input  logic          bit_i,
   input  logic [QW-1:0] divisor_i,
   output logic [QW-1:0] r_next_o,
   output logic          qbit_o
);

   logic [QW:0] t;

   assign t        = {r_i, bit_i};
   assign qbit_o   = (t >= {1'b0, divisor_i});
   // r_i < divisor_i is an invariant, so the difference always fits in QW bits
   assign r_next_o = qbit_o ? QW'(t - {1'b0, divisor_i}) : t[QW-1:0];

endmodule

// File: rtl/unsi_seq_div_24b12b.sv
// Sequential restoring unsigned divider, 24-bit dividend / 12-bit divisor, one quotient bit per cycle.
// Macro UNSI_DIV_REM_OUT_EN: when defined, rem carries the final remainder; otherwise rem is tied to 0.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high (after reset release)
// CALC  | 12 shift/subtract iterations, one per cycle
// DONE  | result presented with out_valid, held until out_ready
module unsi_seq_div_24b12b
   import unsi_div_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [QW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quot,
   output logic [QW-1:0] rem,
   output logic          ovf
);

   state_e        state_q;
   logic [QW-1:0] r_q;
   logic [QW-1:0] q_q;
   logic [QW-1:0] dvs_q;
   logic [CW-1:0] cnt_q;
   logic [QW-1:0] quot_q;
   logic          ovf_q;
   logic          out_valid_q;
   logic          in_ready_q;
   logic [QW-1:0] r_d;
   logic          qbit;

   div_step u_step (
      .r_i       (r_q),
      .bit_i     (q_q[QW-1]),
      .divisor_i (dvs_q),
      .r_next_o  (r_d),
      .qbit_o    (qbit)
   );

`ifdef UNSI_DIV_REM_OUT_EN
   logic [QW-1:0] rem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
      end else if (state_q == IDLE && in_valid && in_ready_q) begin
         rem_q <= '0;
      end else if (state_q == CALC && cnt_q == CNT_LAST) begin
         rem_q <= r_d;
      end
   end

   assign rem = rem_q;
`else
   assign rem = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         quot_q      <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  dvs_q      <= divisor;
                  // Upper half >= divisor means the quotient needs more than QW bits (or divisor is 0)
                  if (dividend[DW-1:QW] >= divisor) begin
                     state_q     <= DONE;
                     quot_q      <= QUOT_SAT;
                     ovf_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= CALC;
                     r_q     <= dividend[DW-1:QW];
                     q_q     <= dividend[QW-1:0];
                     cnt_q   <= '0;
                  end
               end
            end
            CALC: begin
               r_q   <= r_d;
               q_q   <= {q_q[QW-2:0], qbit};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q     <= DONE;
                  quot_q      <= {q_q[QW-2:0], qbit};
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quot      = quot_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_unsi_seq_div_24b12b.sv
// Scoreboard bench for unsi_seq_div_24b12b: driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on each output handshake.
module tb_unsi_seq_div_24b12b;

   typedef struct {
      logic [11:0] quot;
      logic [11:0] rem;
      logic        ovf;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] dividend;
   logic [11:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] quot;
   logic [11:0] rem;
   logic        ovf;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;
   exp_t sb[$];

   unsi_seq_div_24b12b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   // out_ready changes a little after the rising edge, away from the sampling negedge
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division; overflow when the quotient cannot fit in 12 bits
   function automatic exp_t model(input logic [23:0] dvd, input logic [11:0] dvs);
      exp_t e;
      longint q;
      e.acc = 0;
      if (dvs == 0) begin
         q = 4096;
      end else begin
         q = longint'(dvd) / longint'(dvs);
      end
      if (q > 4095) begin
         e.quot = 12'hFFF;
         e.rem  = 12'h000;
         e.ovf  = 1'b1;
      end else begin
         e.quot = 12'(q);
`ifdef UNSI_DIV_REM_OUT_EN
         e.rem  = 12'(longint'(dvd) % longint'(dvs));
`else
         e.rem  = 12'h000;
`endif
         e.ovf  = 1'b0;
      end
      return e;
   endfunction

   task automatic issue(input logic [23:0] dvd, input logic [11:0] dvs);
      exp_t e;
      int   n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         in_valid = 1'b1;
         dividend = dvd;
         divisor  = dvs;
         e        = model(dvd, dvs);
         e.acc    = cyc + 1;
         sb.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         dividend = 24'($urandom);
         divisor  = 12'($urandom);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_quot"},      32'(quot),      32'd0);
      chk({tag, "_rem"},       32'(rem),       32'd0);
      chk({tag, "_ovf"},       32'(ovf),       32'd0);
   endtask

   // Monitor: tracks the first cycle out_valid is seen and whether the result stays put
   initial begin
      logic        prev_valid = 1'b0;
      logic        held_bad   = 1'b0;
      logic [11:0] hq = '0, hr = '0;
      logic        ho = 1'b0;
      int          first_cyc = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               first_cyc = cyc;
               hq = quot;
               hr = rem;
               ho = ovf;
               held_bad = 1'b0;
            end else if (out_valid && (quot !== hq || rem !== hr || ovf !== ho)) begin
               held_bad = 1'b1;
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("quot", 32'(quot), 32'(e.quot));
                  chk("rem",  32'(rem),  32'(e.rem));
                  chk("ovf",  32'(ovf),  32'(e.ovf));
                  chk("held_stable", 32'(held_bad), 32'd0);
                  // Overflow results are registered on the accept edge; computed ones 12 edges later
                  chk("latency", 32'(first_cyc - e.acc), e.ovf ? 32'd0 : 32'd12);
               end
            end
            prev_valid = out_valid;
         end
      end
   end

   initial begin
      logic [11:0] dvs;
      logic [11:0] hi;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      dividend = '0;
      divisor  = '0;
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);

      issue(24'd1000, 12'd7);
      drain();
      issue(24'hFFEFFF, 12'hFFF);
      issue(24'h00A000, 12'd10);
      issue(24'h123456, 12'd0);
      issue(24'h000000, 12'd0);
      drain();

      // Backpressure with in_valid pulses while busy
      rdy_mode = 2;
      issue(24'd1000, 12'd7);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("busy_in_ready", 32'(in_ready), 32'd0);
         in_valid = (i % 2 == 0);
         dividend = 24'($urandom);
         divisor  = 12'($urandom);
      end
      in_valid = 1'b0;
      wait_valid();
      repeat (20) @(negedge clk);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_pending", 32'(sb.size()), 32'd1);
      rdy_mode = 0;
      for (int n = 0; n < 10 && out_valid; n++) @(negedge clk);
      chk("bp_out_valid_dropped", 32'(out_valid), 32'd0);
      chk("bp_in_ready_next", 32'(in_ready), 32'd1);
      chk("bp_single_handshake", 32'(sb.size()), 32'd0);

      // Reset during iteration 5
      issue(24'd1000, 12'd7);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("rst_calc");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(24'd200, 12'd9);
      drain();

      // Reset while a result is held
      rdy_mode = 2;
      issue(24'd200, 12'd9);
      wait_valid();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("rst_done");
      sb.delete();
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(24'd1000, 12'd7);
      drain();

      // Randomized mix with random out_ready
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            dvs = 12'($urandom_range(1, 4095));
            hi  = 12'($urandom_range(0, int'(dvs) - 1));
            issue({hi, 12'($urandom)}, dvs);
         end else begin
            issue(24'($urandom), ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom));
         end
      end
      rdy_mode = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
